// File: rtl/panel_input.sv
// panel_input: synchronises, debounces and edge-detects board buttons,
// then derives the single-step clock and the display-select counter.
module panel_input #(
   parameter int          NBTN       = 6,
   parameter int          DEB_CYCLES = 1000000,
   parameter int          CNT_W      = 20,
   parameter int          STEP_IDX   = 1,
   parameter int          SEL_IDX    = 5,
   parameter logic [2:0]  SEL_MAX    = 3'd7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NBTN-1:0] swb_raw,
   input  logic [31:0]     sw_raw,
   output logic [31:0]     sw_sync,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_pulse,
   output logic            step_clk,
   output logic [15:0]     step_cnt,
   output logic [2:0]      sel
);

   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_CYCLES - 1);

   logic [31:0]     sw_s1;
   logic [NBTN-1:0] b_s1;
   logic [NBTN-1:0] b_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_s1   <= '0;
         sw_sync <= '0;
         b_s1    <= '0;
         b_s2    <= '0;
      end else begin
         sw_s1   <= sw_raw;
         sw_sync <= sw_s1;
         b_s1    <= swb_raw;
         b_s2    <= b_s1;
      end
   end

   for (genvar i = 0; i < NBTN; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;
      logic             lvl_q;
      logic             pul_q;

      // pulse is set on the same edge the level rises, so both read 1 together
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt   <= '0;
            lvl_q <= 1'b0;
            pul_q <= 1'b0;
         end else begin
            pul_q <= 1'b0;
            if (b_s2[i] == lvl_q) begin
               cnt <= '0;
            end else if (cnt == CNT_TOP) begin
               lvl_q <= b_s2[i];
               pul_q <= b_s2[i];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

      assign btn_level[i] = lvl_q;
      assign btn_pulse[i] = pul_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_clk <= 1'b0;
         step_cnt <= '0;
         sel      <= '0;
      end else begin
         if (btn_pulse[STEP_IDX]) begin
            step_clk <= ~step_clk;
            step_cnt <= step_cnt + 16'd1;
         end
         if (btn_pulse[SEL_IDX]) begin
            sel <= (sel >= SEL_MAX) ? 3'd0 : sel + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_panel_input.sv
// tb_panel_input: directed vectors and corner sequences for panel_input
// with a short debounce window.
module tb_panel_input;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  swb_raw;
   logic [31:0] sw_raw;

   logic [31:0] sw_sync, sw_sync5;
   logic [5:0]  btn_level, btn_level5;
   logic [5:0]  btn_pulse, btn_pulse5;
   logic        step_clk, step_clk5;
   logic [15:0] step_cnt, step_cnt5;
   logic [2:0]  sel, sel5;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   panel_input #(
      .NBTN(6), .DEB_CYCLES(4), .CNT_W(3),
      .STEP_IDX(1), .SEL_IDX(5), .SEL_MAX(3'd7)
   ) dut (
      .clk(clk), .rst(rst),
      .swb_raw(swb_raw), .sw_raw(sw_raw),
      .sw_sync(sw_sync), .btn_level(btn_level),
      .btn_pulse(btn_pulse), .step_clk(step_clk),
      .step_cnt(step_cnt), .sel(sel)
   );

   panel_input #(
      .NBTN(6), .DEB_CYCLES(4), .CNT_W(3),
      .STEP_IDX(1), .SEL_IDX(5), .SEL_MAX(3'd5)
   ) dut5 (
      .clk(clk), .rst(rst),
      .swb_raw(swb_raw), .sw_raw(sw_raw),
      .sw_sync(sw_sync5), .btn_level(btn_level5),
      .btn_pulse(btn_pulse5), .step_clk(step_clk5),
      .step_cnt(step_cnt5), .sel(sel5)
   );

   typedef struct {
      bit          r;
      logic [5:0]  swb;
      logic [5:0]  lvl;
      logic [5:0]  pul;
      logic        sc;
      logic [15:0] cnt;
      logic [2:0]  sel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input logic [5:0] swb,
                      input logic [5:0] lvl, input logic [5:0] pul,
                      input logic sc, input logic [15:0] cnt,
                      input logic [2:0] sel);
      vec_t v;
      v.r = r; v.swb = swb; v.lvl = lvl; v.pul = pul;
      v.sc = sc; v.cnt = cnt; v.sel = sel;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      swb_raw = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic press(input logic [5:0] m);
      @(negedge clk);
      swb_raw = m;
      repeat (10) @(posedge clk);
      @(negedge clk);
      swb_raw = '0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] m7, m5;
      rst = 1'b0;
      swb_raw = '0;
      sw_raw = '0;

      // reset with inputs active, then 20 idle cycles
      add(0, 6'h3F, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) add(1, 0, 0, 0, 0, 0, 0);

      // clean press on button 5 then release
      add(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(1, 6'h20, 0, 0, 0, 0, 0);
      add(1, 6'h20, 6'h20, 6'h20, 0, 0, 0);
      add(1, 6'h20, 6'h20, 0, 0, 0, 1);
      add(1, 6'h20, 6'h20, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(1, 0, 6'h20, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0, 1);

      // bouncing button 1, then held
      add(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 12; k++)
         add(1, ((k / 3) % 2 == 0) ? 6'h02 : 6'h00, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) add(1, 6'h02, 0, 0, 0, 0, 0);
      add(1, 6'h02, 6'h02, 6'h02, 0, 0, 0);
      add(1, 6'h02, 6'h02, 0, 1, 1, 0);
      add(1, 6'h02, 6'h02, 0, 1, 1, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].r;
         swb_raw = tbl[i].swb;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i),
             {btn_level, btn_pulse, step_clk, step_cnt, sel},
             {tbl[i].lvl, tbl[i].pul, tbl[i].sc, tbl[i].cnt,
              tbl[i].sel});
      end

      // select wrap for SEL_MAX 7 and 5
      do_reset();
      m7 = 0;
      m5 = 0;
      for (int k = 1; k <= 8; k++) begin
         press(6'h20);
         m7 = (m7 == 3'd7) ? 3'd0 : m7 + 3'd1;
         m5 = (m5 == 3'd5) ? 3'd0 : m5 + 3'd1;
         chk($sformatf("sel7_p%0d", k), 32'(sel), 32'(m7));
         chk($sformatf("sel5_p%0d", k), 32'(sel5), 32'(m5));
      end

      // simultaneous step and select press
      do_reset();
      @(negedge clk);
      swb_raw = 6'h22;
      repeat (6) @(posedge clk);
      #1;
      chk("simul_pulse", 32'(btn_pulse), 32'h22);
      chk("simul_pre", {step_clk, sel}, 32'h0);
      @(posedge clk);
      #1;
      chk("simul_post", {step_clk, step_cnt, sel},
          {1'b1, 16'd1, 3'd1});
      @(negedge clk);
      swb_raw = '0;
      repeat (10) @(posedge clk);

      // step counter wrap from 0xFFFF
      @(negedge clk);
      force dut.step_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.step_cnt;
      press(6'h02);
      chk("cnt_wrap", 32'(step_cnt), 32'h0);
      chk("wrap_stepclk", 32'(step_clk), 32'h0);

      // reset in the middle of a debounce
      @(negedge clk);
      swb_raw = 6'h02;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_clear", {btn_level, step_clk, step_cnt, sel},
          32'h0);
      chk("midrst_sel5", 32'(sel5), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_early", 32'(btn_level), 32'h0);
      @(posedge clk);
      #1;
      chk("midrst_press", {btn_level, btn_pulse}, {6'h02, 6'h02});

      // switch synchroniser latency
      @(negedge clk);
      sw_raw = 32'hA5A5_0F0F;
      @(posedge clk);
      #1;
      chk("sw_edge0", sw_sync, 32'h0);
      @(posedge clk);
      #1;
      chk("sw_edge1", sw_sync, 32'hA5A5_0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
